// File: rtl/pic_interrupt_sequencer_if.sv
// Signal bundle between the 8259-style PIC IRR/CPU side and the interrupt sequencer.
// The slave modport is the sequencer; the master modport is the surrounding PIC logic or bench.
interface pic_interrupt_sequencer_if;
  logic [7:0] irr;
  logic       inta_n;
  logic [4:0] vec_base;
  logic       aeoi_en;
  logic       rotate_en;
  logic       eoi_ns;
  logic       eoi_sp;
  logic [2:0] eoi_lvl;
  logic       int_o;
  logic       freeze;
  logic [7:0] clear_interrupt_request;
  logic [7:0] isr;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (
    output irr, inta_n, vec_base, aeoi_en, rotate_en, eoi_ns, eoi_sp, eoi_lvl,
    input  int_o, freeze, clear_interrupt_request, isr, data_out, data_oe
  );

  modport slave (
    input  irr, inta_n, vec_base, aeoi_en, rotate_en, eoi_ns, eoi_sp, eoi_lvl,
    output int_o, freeze, clear_interrupt_request, isr, data_out, data_oe
  );
endinterface

// File: rtl/pic_interrupt_sequencer.sv
// Priority resolver, in-service register and two-pulse INTA sequencer for an 8259-style PIC.
// Latency: inta_n edge to output change is INTA_SYNC+1 clocks; int_o is registered.
// No backpressure: the CPU paces the handshake through inta_n, EOI strobes are taken every cycle.
module pic_interrupt_sequencer #(
  parameter int         INTA_SYNC = 2,
  parameter logic [2:0] LP_RESET  = 3'd7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pic_interrupt_sequencer_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT1, S_ACK1, S_WAIT2, S_ACK2} state_t;

  state_t r_state, w_state_nxt;

  logic [INTA_SYNC-1:0] r_sync;
  logic                 r_inta_q;
  logic                 w_fall, w_rise;

  logic [7:0] r_isr, w_isr_nxt;
  logic [2:0] r_lp, w_lp_nxt;
  logic [2:0] r_lvl;
  logic       r_spur;
  logic       r_int, r_freeze, r_oe;
  logic [7:0] r_clr, r_dout;

  logic       w_win_vld, w_ceil_vld, w_elig;
  logic [2:0] w_win, w_ceil, w_win_rank, w_ceil_rank;
  logic       w_ack1, w_ack2, w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '1;
      r_inta_q <= 1'b1;
    end else begin
      r_sync   <= {r_sync[INTA_SYNC-2:0], bus.inta_n};
      r_inta_q <= r_sync[INTA_SYNC-1];
    end
  end

  assign w_fall = r_inta_q & ~r_sync[INTA_SYNC-1];
  assign w_rise = ~r_inta_q & r_sync[INTA_SYNC-1];

  // Scan from lowest to highest priority so the last hit is the highest-priority one.
  always_comb begin
    logic [2:0] v_idx;
    w_win_vld   = 1'b0;
    w_win       = 3'd0;
    w_win_rank  = 3'd0;
    w_ceil_vld  = 1'b0;
    w_ceil      = 3'd0;
    w_ceil_rank = 3'd0;
    v_idx       = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      v_idx = r_lp + 3'(k + 1);
      if (bus.irr[v_idx]) begin
        w_win_vld  = 1'b1;
        w_win      = v_idx;
        w_win_rank = 3'(k);
      end
      if (r_isr[v_idx]) begin
        w_ceil_vld  = 1'b1;
        w_ceil      = v_idx;
        w_ceil_rank = 3'(k);
      end
    end
  end

  assign w_elig = w_win_vld && (!w_ceil_vld || (w_win_rank < w_ceil_rank));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack1      = 1'b0;
    w_ack2      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE:  if (w_elig) w_state_nxt = S_WAIT1;
      S_WAIT1: if (w_fall) begin w_state_nxt = S_ACK1;  w_ack1 = 1'b1; end
      S_ACK1:  if (w_rise) w_state_nxt = S_WAIT2;
      S_WAIT2: if (w_fall) begin w_state_nxt = S_ACK2;  w_ack2 = 1'b1; end
      S_ACK2:  if (w_rise) begin w_state_nxt = S_IDLE;  w_done = 1'b1; end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // EOI acts on the pre-set ISR; the INTA1 set and AEOI clear are layered on top.
  always_comb begin
    w_isr_nxt = r_isr;
    w_lp_nxt  = r_lp;
    if (bus.eoi_sp) begin
      w_isr_nxt[bus.eoi_lvl] = 1'b0;
    end else if (bus.eoi_ns && w_ceil_vld) begin
      w_isr_nxt[w_ceil] = 1'b0;
      if (bus.rotate_en) w_lp_nxt = w_ceil;
    end
    if (w_ack1 && w_elig) w_isr_nxt[w_win] = 1'b1;
    if (w_done && bus.aeoi_en && !r_spur) begin
      w_isr_nxt[r_lvl] = 1'b0;
      if (bus.rotate_en) w_lp_nxt = r_lvl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_isr    <= 8'h00;
      r_lp     <= LP_RESET;
      r_lvl    <= 3'd0;
      r_spur   <= 1'b0;
      r_int    <= 1'b0;
      r_freeze <= 1'b0;
      r_oe     <= 1'b0;
      r_clr    <= 8'h00;
      r_dout   <= 8'h00;
    end else begin
      r_isr <= w_isr_nxt;
      r_lp  <= w_lp_nxt;
      r_int <= w_elig && ((w_state_nxt == S_IDLE) || (w_state_nxt == S_WAIT1));
      r_clr <= (w_ack1 && w_elig) ? (8'h01 << w_win) : 8'h00;
      if (w_ack1) begin
        r_freeze <= 1'b1;
        r_lvl    <= w_elig ? w_win : 3'd7;
        r_spur   <= !w_elig;
      end
      if (w_ack2) begin
        r_dout <= {bus.vec_base, r_lvl};
        r_oe   <= 1'b1;
      end
      if (w_done) begin
        r_dout   <= 8'h00;
        r_oe     <= 1'b0;
        r_freeze <= 1'b0;
      end
    end
  end

  assign bus.int_o                   = r_int;
  assign bus.freeze                  = r_freeze;
  assign bus.clear_interrupt_request = r_clr;
  assign bus.isr                     = r_isr;
  assign bus.data_out                = r_dout;
  assign bus.data_oe                 = r_oe;

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// Directed bench for the PIC interrupt sequencer: hand-computed vectors, immediate assertions.
module tb_pic_interrupt_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  pic_interrupt_sequencer_if bus();

  pic_interrupt_sequencer #(.INTA_SYNC(2), .LP_RESET(3'd7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full INTA pair; the bench plays the IRR and drops the acknowledged request bit.
  task automatic inta_pair(input string tag, input logic [7:0] exp_clr, input logic [7:0] exp_vec);
    bus.inta_n = 1'b0;
    step(3);
    check({tag, "_clr"}, bus.clear_interrupt_request, exp_clr);
    check({tag, "_frz1"}, {7'd0, bus.freeze}, 8'd1);
    check({tag, "_int0"}, {7'd0, bus.int_o}, 8'd0);
    bus.irr = bus.irr & ~exp_clr;
    step(1);
    check({tag, "_clr_end"}, bus.clear_interrupt_request, 8'h00);
    bus.inta_n = 1'b1;
    step(3);
    bus.inta_n = 1'b0;
    step(3);
    check({tag, "_oe1"}, {7'd0, bus.data_oe}, 8'd1);
    check({tag, "_vec"}, bus.data_out, exp_vec);
    bus.inta_n = 1'b1;
    step(3);
    check({tag, "_oe0"}, {7'd0, bus.data_oe}, 8'd0);
    check({tag, "_frz0"}, {7'd0, bus.freeze}, 8'd0);
    check({tag, "_dout0"}, bus.data_out, 8'h00);
  endtask

  task automatic eoi_ns_pulse();
    bus.eoi_ns = 1'b1;
    step(1);
    bus.eoi_ns = 1'b0;
  endtask

  initial begin
    bus.irr = 8'h00; bus.inta_n = 1'b1; bus.vec_base = 5'h11;
    bus.aeoi_en = 1'b0; bus.rotate_en = 1'b0;
    bus.eoi_ns = 1'b0; bus.eoi_sp = 1'b0; bus.eoi_lvl = 3'd0;
    step(2);
    check("rst_int", {7'd0, bus.int_o}, 8'd0);
    check("rst_isr", bus.isr, 8'h00);
    check("rst_frz", {7'd0, bus.freeze}, 8'd0);
    check("rst_oe", {7'd0, bus.data_oe}, 8'd0);
    check("rst_clr", bus.clear_interrupt_request, 8'h00);
    check("rst_dout", bus.data_out, 8'h00);
    rst_n = 1'b1;
    step(1);

    // IR3 beats IR5 with reset priority
    bus.irr = 8'h28;
    step(1);
    check("t1_int", {7'd0, bus.int_o}, 8'd1);
    bus.irr = 8'h08;
    inta_pair("t1", 8'h08, 8'h8B);
    check("t1_isr", bus.isr, 8'h08);

    // IR6 is masked by in-service IR3; IR2 outranks it
    bus.irr = 8'h40;
    step(2);
    check("t2_int_blk", {7'd0, bus.int_o}, 8'd0);
    bus.irr = 8'h44;
    step(1);
    check("t2_int", {7'd0, bus.int_o}, 8'd1);
    inta_pair("t2", 8'h04, 8'h8A);
    check("t2_isr", bus.isr, 8'h0C);
    bus.irr = 8'h00;
    bus.eoi_ns = 1'b1; bus.eoi_sp = 1'b1; bus.eoi_lvl = 3'd3;
    step(1);
    bus.eoi_ns = 1'b0; bus.eoi_sp = 1'b0;
    check("t2_sp_wins", bus.isr, 8'h04);
    eoi_ns_pulse();
    check("t2_ns", bus.isr, 8'h00);

    // rotation: after EOI of IR0, IR0 becomes lowest priority
    bus.irr = 8'h01;
    step(1);
    check("t3_int", {7'd0, bus.int_o}, 8'd1);
    inta_pair("t3a", 8'h01, 8'h88);
    check("t3_isr1", bus.isr, 8'h01);
    bus.rotate_en = 1'b1;
    eoi_ns_pulse();
    check("t3_isr0", bus.isr, 8'h00);
    bus.irr = 8'h81;
    step(1);
    check("t3_int2", {7'd0, bus.int_o}, 8'd1);
    inta_pair("t3b", 8'h80, 8'h8F);
    check("t3_isr7", bus.isr, 8'h80);
    step(1);
    check("t3_ir0_blk", {7'd0, bus.int_o}, 8'd0);
    bus.irr = 8'h00;
    eoi_ns_pulse();
    check("t3_isr_clr", bus.isr, 8'h00);
    bus.rotate_en = 1'b0;
    step(1);

    // automatic EOI
    bus.aeoi_en = 1'b1;
    bus.irr = 8'h10;
    step(1);
    check("t4_int", {7'd0, bus.int_o}, 8'd1);
    inta_pair("t4", 8'h10, 8'h8C);
    check("t4_isr", bus.isr, 8'h00);
    bus.aeoi_en = 1'b0;

    // request withdrawn before INTA1: spurious vector
    bus.irr = 8'h02;
    step(1);
    check("t5_int", {7'd0, bus.int_o}, 8'd1);
    bus.irr = 8'h00;
    step(1);
    check("t5_int_drop", {7'd0, bus.int_o}, 8'd0);
    inta_pair("t5", 8'h00, 8'h8F);
    check("t5_isr", bus.isr, 8'h00);

    // reset in the middle of the handshake
    bus.irr = 8'h08;
    step(1);
    bus.inta_n = 1'b0;
    step(3);
    bus.irr = 8'h00;
    bus.inta_n = 1'b1;
    step(3);
    check("t6_frz_pre", {7'd0, bus.freeze}, 8'd1);
    check("t6_isr_pre", bus.isr, 8'h08);
    rst_n = 1'b0;
    #1;
    check("t6_int", {7'd0, bus.int_o}, 8'd0);
    check("t6_frz", {7'd0, bus.freeze}, 8'd0);
    check("t6_oe", {7'd0, bus.data_oe}, 8'd0);
    check("t6_isr", bus.isr, 8'h00);
    step(2);
    rst_n = 1'b1;
    step(1);
    bus.irr = 8'h81;
    step(1);
    check("t6_int2", {7'd0, bus.int_o}, 8'd1);
    inta_pair("t6", 8'h01, 8'h88);
    check("t6_isr_post", bus.isr, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
